// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port integer register file with a per-register pending-write scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data and clear busy on the read ports.
module regfile_sb #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_wr,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue,
    input  logic [ADDR_W-1:0]        issue_rd,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      sb_pend
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_pend_nxt;
    logic                w_wr_en;

    assign w_wr_en = reg_wr && (waddr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Issue is applied after the writeback clear so a new producer stays outstanding.
    always_comb begin
        w_pend_nxt = r_pend;
        if (flush) begin
            w_pend_nxt = '0;
        end else begin
            if (reg_wr) begin
                w_pend_nxt[waddr] = 1'b0;
            end
            if (issue) begin
                w_pend_nxt[issue_rd] = 1'b1;
            end
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign sb_pend = r_pend;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        logic [DATA_W-1:0] w_rdata;
        logic              w_busy;

        assign w_raddr = raddr[i*ADDR_W +: ADDR_W];

`ifdef REGFILE_SB_BYPASS_EN
        logic w_fwd;

        // Forwarding is gated by reset so outputs read zero while reset is held.
        assign w_fwd = reset && w_wr_en && (w_raddr == waddr);

        always_comb begin
            w_rdata = r_regs[w_raddr];
            w_busy  = r_pend[w_raddr];
            if (w_raddr == '0) begin
                w_rdata = '0;
                w_busy  = 1'b0;
            end else if (w_fwd) begin
                w_rdata = wdata;
                w_busy  = issue && (issue_rd == waddr);
            end
        end
`else
        always_comb begin
            w_rdata = r_regs[w_raddr];
            w_busy  = r_pend[w_raddr];
            if (w_raddr == '0) begin
                w_rdata = '0;
                w_busy  = 1'b0;
            end
        end
`endif

        assign rdata[i*DATA_W +: DATA_W] = w_rdata;
        assign rd_busy[i]                = w_busy;
    end

endmodule
